// File: rtl/fp_nextafter_n.sv
// rtl/fp_nextafter_n.sv - multi-ULP nextafter: step a toward b by n ULPs, clamped at b (option: FPNA_INF_SAT_EN)
module fp_nextafter_n #(
    parameter int FPWID  = 32,
    parameter int EXPWID = 8,
    parameter int CNTW   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ce,
    input  logic              ld,
    input  logic [FPWID-1:0]  a,
    input  logic [FPWID-1:0]  b,
    input  logic [CNTW-1:0]   n,
    output logic              busy,
    output logic              done,
    output logic [FPWID-1:0]  o,
    output logic              ovf,
    output logic              unf,
    output logic              inv
);

    localparam int SIGW = FPWID - EXPWID - 1;
    localparam int KW   = FPWID + 1;
    localparam int SW   = FPWID + 2;

    localparam logic [FPWID-1:0] QBIT =
        {{(EXPWID + 1){1'b0}}, 1'b1, {(SIGW - 1){1'b0}}};
    localparam logic [FPWID-2:0] MAX_FIN_MAG =
        {{(EXPWID - 1){1'b1}}, 1'b0, {SIGW{1'b1}}};

    typedef enum logic [1:0] {IDLE, CMP, STEP, FIN} state_t;

    state_t state, state_nx;

    // Captured operands
    logic [FPWID-1:0] a_r, b_r;
    logic [CNTW-1:0]  n_r;

    // Classification and ordered keys, registered in CMP
    logic signed [KW-1:0] ka_r, kb_r;
    logic                 nan_a_r, nan_b_r, snan_r, a_fin_r, a_nz_r;

    // Stepped key, registered in STEP
    logic signed [SW-1:0] kr_r;

    // Ordered key: +magnitude for positive, -magnitude for negative; both zeros map to 0
    function automatic logic signed [KW-1:0] to_key(input logic [FPWID-1:0] v);
        logic signed [KW-1:0] m;
        m = signed'({2'b00, v[FPWID-2:0]});
        return v[FPWID-1] ? -m : m;
    endfunction

    function automatic logic is_nan(input logic [FPWID-1:0] v);
        return (&v[FPWID-2 -: EXPWID]) && (|v[SIGW-1:0]);
    endfunction

    function automatic logic is_snan(input logic [FPWID-1:0] v);
        return is_nan(v) && !v[SIGW-1];
    endfunction

    assign busy = (state != IDLE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else if (ce)
            state <= state_nx;
    end

    // Next-state: fixed four-phase sequence once a load is taken
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (ld) state_nx = CMP;
            CMP:  state_nx = STEP;
            STEP: state_nx = FIN;
            FIN:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // STEP arithmetic on FPWID+2 bits so ka +/- n cannot wrap
    logic signed [SW-1:0] ka_x, kb_x, n_x, up, dn, kr_nx;
    always_comb begin
        ka_x  = {ka_r[KW-1], ka_r};
        kb_x  = {kb_r[KW-1], kb_r};
        n_x   = signed'({{(SW - CNTW){1'b0}}, n_r});
        up    = ka_x + n_x;
        dn    = ka_x - n_x;
        kr_nx = ka_x;
        if (ka_r < kb_r)
            kr_nx = (up > kb_x) ? kb_x : up;
        else if (ka_r > kb_r)
            kr_nx = (dn < kb_x) ? kb_x : dn;
    end

    // FIN result selection and flag generation
    logic [FPWID-1:0] res;
    logic [FPWID-2:0] kr_mag;
    logic             kr_sign, res_inf, ovf_nx, unf_nx;
    always_comb begin
        kr_mag  = (FPWID-1)'(kr_r[SW-1] ? -kr_r : kr_r);
        kr_sign = (kr_r == '0) ? a_r[FPWID-1] : kr_r[SW-1];
        if (nan_a_r)
            res = a_r | QBIT;
        else if (nan_b_r)
            res = b_r | QBIT;
        else if (ka_r == kb_r)
            res = b_r;
        else if (n_r == '0)
            res = a_r;
        else if (kr_r == kb_x)
            res = b_r;
        else
            res = {kr_sign, kr_mag};
        res_inf = (&res[FPWID-2 -: EXPWID]) && !(|res[SIGW-1:0]);
        ovf_nx  = a_fin_r && res_inf;
`ifdef FPNA_INF_SAT_EN
        if (ovf_nx)
            res = {res[FPWID-1], MAX_FIN_MAG};
`endif
        unf_nx = a_nz_r && (res[FPWID-2 -: EXPWID] == '0);
    end

    // Operand capture, CMP classification and STEP key registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r     <= '0;
            b_r     <= '0;
            n_r     <= '0;
            ka_r    <= '0;
            kb_r    <= '0;
            nan_a_r <= 1'b0;
            nan_b_r <= 1'b0;
            snan_r  <= 1'b0;
            a_fin_r <= 1'b0;
            a_nz_r  <= 1'b0;
            kr_r    <= '0;
        end else if (ce) begin
            case (state)
                IDLE: if (ld) begin
                    a_r <= a;
                    b_r <= b;
                    n_r <= n;
                end
                CMP: begin
                    ka_r    <= to_key(a_r);
                    kb_r    <= to_key(b_r);
                    nan_a_r <= is_nan(a_r);
                    nan_b_r <= is_nan(b_r);
                    snan_r  <= is_snan(a_r) || is_snan(b_r);
                    a_fin_r <= !(&a_r[FPWID-2 -: EXPWID]);
                    a_nz_r  <= (a_r[FPWID-2:0] != '0);
                end
                STEP: kr_r <= kr_nx;
                default: ;
            endcase
        end
    end

    // Output register: result and flags update only on the FIN edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done <= 1'b0;
            o    <= '0;
            ovf  <= 1'b0;
            unf  <= 1'b0;
            inv  <= 1'b0;
        end else if (ce) begin
            done <= (state == FIN);
            if (state == FIN) begin
                o   <= res;
                ovf <= ovf_nx;
                unf <= unf_nx;
                inv <= snan_r;
            end
        end
    end

endmodule

// File: tb/tb_fp_nextafter_n.sv
// tb/tb_fp_nextafter_n.sv - scoreboard bench for fp_nextafter_n (FPWID=32, EXPWID=8)
module tb_fp_nextafter_n;

    logic        clk = 1'b0;
    logic        rst_n, ce, ld;
    logic [31:0] a, b, o;
    logic [7:0]  n;
    logic        busy, done, ovf, unf, inv;

    typedef struct {
        logic [31:0] o;
        logic        ovf;
        logic        unf;
        logic        inv;
    } exp_t;

    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;

    fp_nextafter_n #(.FPWID(32), .EXPWID(8), .CNTW(8)) dut (
        .clk(clk), .rst_n(rst_n), .ce(ce), .ld(ld),
        .a(a), .b(b), .n(n),
        .busy(busy), .done(done), .o(o),
        .ovf(ovf), .unf(unf), .inv(inv)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed %08h expected %08h", tag, obs, expv);
    endtask

    // Wait for done (bounded), check latency from ld assertion, then pop and compare
    task automatic wait_check(input string tag, input int start_cycles);
        exp_t e;
        int   cyc;
        cyc = start_cycles;
        while (!done && cyc < 16) begin
            @(negedge clk);
            cyc++;
        end
        if (!done) begin
            chk({tag, "_timeout"}, 32'd0, 32'd1);
            if (sb.size() > 0) void'(sb.pop_front());
        end else begin
            e = sb.pop_front();
            chk({tag, "_lat"}, cyc, 4);
            chk({tag, "_o"},   o,   e.o);
            chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, e.ovf});
            chk({tag, "_unf"}, {31'd0, unf}, {31'd0, e.unf});
            chk({tag, "_inv"}, {31'd0, inv}, {31'd0, e.inv});
        end
    endtask

    task automatic do_op(input logic [31:0] ta, input logic [31:0] tb, input logic [7:0] tn,
                         input logic [31:0] eo, input logic eovf, input logic eunf,
                         input logic einv, input string tag);
        sb.push_back('{eo, eovf, eunf, einv});
        @(negedge clk);
        a = ta; b = tb; n = tn; ld = 1'b1;
        @(negedge clk);
        ld = 1'b0;
        a = 32'hDEADBEEF; b = 32'h12345678; n = 8'hFF;
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
        wait_check(tag, 1);
    endtask

    initial begin
        int cnt;
        logic [31:0] sat_o;
        rst_n = 1'b0; ce = 1'b1; ld = 1'b0; a = '0; b = '0; n = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_o",    o, 32'd0);
        chk("rst_flags", {29'd0, ovf, unf, inv}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(32'h3F800000, 32'h40000000, 8'd1,  32'h3F800001, 0, 0, 0, "step1");
        do_op(32'h3F800000, 32'h3F800002, 8'd10, 32'h3F800002, 0, 0, 0, "clamp");
        do_op(32'h00000001, 32'hBF800000, 8'd3,  32'h80000002, 0, 1, 0, "cross");
`ifdef FPNA_INF_SAT_EN
        sat_o = 32'h7F7FFFFF;
`else
        sat_o = 32'h7F800000;
`endif
        do_op(32'h7F7FFFFF, 32'h7F800000, 8'd1,  sat_o,        1, 0, 0, "ovf");
        do_op(32'h7FA00000, 32'h3F800000, 8'd5,  32'h7FE00000, 0, 0, 1, "snan");
        do_op(32'h3F800000, 32'h7FC00001, 8'd5,  32'h7FC00001, 0, 0, 0, "qnan_b");
        do_op(32'h80000000, 32'h00000000, 8'd5,  32'h00000000, 0, 0, 0, "zeros");
        do_op(32'h3F800000, 32'h40000000, 8'd0,  32'h3F800000, 0, 0, 0, "n0");
        do_op(32'hBF800000, 32'hC0000000, 8'd2,  32'hBF800002, 0, 0, 0, "neg_dn");
        do_op(32'h80000002, 32'h00000005, 8'd2,  32'h80000000, 0, 1, 0, "to_zero");

        // ce low holds done and the result
        ce = 1'b0;
        repeat (3) @(negedge clk);
        chk("ce_hold_done", {31'd0, done}, 32'd1);
        chk("ce_hold_o", o, 32'h80000000);
        ce = 1'b1;
        @(negedge clk);
        chk("ce_release_done", {31'd0, done}, 32'd0);

        // ld while busy is ignored and not queued
        sb.push_back('{32'h3F800001, 1'b0, 1'b0, 1'b0});
        @(negedge clk);
        a = 32'h3F800000; b = 32'h40000000; n = 8'd1; ld = 1'b1;
        @(negedge clk);
        ld = 1'b0;
        @(negedge clk);
        a = 32'h40000000; b = 32'h00000000; n = 8'd7; ld = 1'b1;
        @(negedge clk);
        ld = 1'b0;
        wait_check("busy_ld", 3);
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) cnt++;
        end
        chk("busy_ld_no_extra", cnt, 0);

        // Reset mid-operation discards it
        @(negedge clk);
        a = 32'h3F800000; b = 32'h00000000; n = 8'd3; ld = 1'b1;
        @(negedge clk);
        ld = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_o", o, 32'd0);
        chk("midrst_flags", {29'd0, ovf, unf, inv}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) cnt++;
        end
        chk("midrst_no_done", cnt, 0);
        do_op(32'h3F800000, 32'h00000000, 8'd3, 32'h3F7FFFFD, 0, 0, 0, "after_rst");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
